// File: rtl/board_io_pkg.sv
// Shared register map, field widths and bus types for the board input port.
package board_io_pkg;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h0000_2000;

    localparam int SW_W  = 10;
    localparam int BTN_W = 4;

    localparam logic [3:0] OFF_SW     = 4'h0;
    localparam logic [3:0] OFF_BTN    = 4'h4;
    localparam logic [3:0] OFF_EDGE   = 4'h8;
    localparam logic [3:0] OFF_IRQ_EN = 4'hC;

    typedef enum logic [1:0] {
        REG_SW     = 2'd0,
        REG_BTN    = 2'd1,
        REG_EDGE   = 2'd2,
        REG_IRQ_EN = 2'd3
    } reg_sel_e;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_PEND,
        BUS_ACK
    } bus_state_e;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } bus_rsp_t;

    // Word offsets map one-to-one onto the register select encoding.
    function automatic reg_sel_e reg_sel(input logic [3:0] off);
        return reg_sel_e'(off[3:2]);
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// One input bit: 2-flop synchronizer followed by a saturating-counter debouncer.
module debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync0;
    logic          sync1;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
            dout  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync0 <= din;
            sync1 <= sync0;
            // The disagreeing cycle that reaches CNT_LAST is the last one required.
            if (sync1 == dout) begin
                cnt <= '0;
            end else if (cnt >= CNT_LAST) begin
                dout <= sync1;
                cnt  <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/board_input_port.sv
// Debounced switch/button register block with W1C button-edge latch and level irq.
module board_input_port
    import board_io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = BASE_ADDR_DEFAULT,
    parameter int          DEBOUNCE_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  sw,
    input  logic [3:0]  btn,
    input  logic        busReq,
    input  logic        busWe,
    input  logic [31:0] busAddr,
    input  logic [31:0] busWData,
    output logic [31:0] busRData,
    output logic        busAck,
    output logic        busErr,
    output logic        irq
);

    localparam int NIN = SW_W + BTN_W;

    logic [NIN-1:0]   raw;
    logic [NIN-1:0]   deb;
    logic [SW_W-1:0]  sw_deb;
    logic [BTN_W-1:0] btn_deb;

    assign raw     = {btn, sw};
    assign sw_deb  = deb[SW_W-1:0];
    assign btn_deb = deb[NIN-1:SW_W];

    genvar gi;
    generate
        for (gi = 0; gi < NIN; gi++) begin : g_cell
            debounce_cell #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_cell (
                .clk  (clk),
                .rst_n(rst_n),
                .din  (raw[gi]),
                .dout (deb[gi])
            );
        end
    endgenerate

    bus_state_e       state;
    bus_rsp_t         cap;
    logic [BTN_W-1:0] btn_prev;
    logic [BTN_W-1:0] btn_edge;
    logic [BTN_W-1:0] irq_en;

    reg_sel_e         sel;
    logic             req_err;
    logic             accept;
    logic             wr_edge;
    logic             wr_irq_en;
    logic [BTN_W-1:0] edge_clr;
    logic [BTN_W-1:0] btn_rise;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign unused_wdata = ^busWData[31:BTN_W];

    always_comb begin
        sel     = reg_sel(busAddr[3:0]);
        req_err = (busAddr[31:4] != BASE_ADDR[31:4]) || (busAddr[1:0] != 2'b00)
                  || (busWe && (sel == REG_SW || sel == REG_BTN));
        accept  = busReq && (state == BUS_IDLE);

        rd_mux = '0;
        case (sel)
            REG_SW:     rd_mux[SW_W-1:0]  = sw_deb;
            REG_BTN:    rd_mux[BTN_W-1:0] = btn_deb;
            REG_EDGE:   rd_mux[BTN_W-1:0] = btn_edge;
            REG_IRQ_EN: rd_mux[BTN_W-1:0] = irq_en;
            default:    rd_mux = '0;
        endcase

        wr_edge   = accept && busWe && !req_err && (sel == REG_EDGE);
        wr_irq_en = accept && busWe && !req_err && (sel == REG_IRQ_EN);
        edge_clr  = wr_edge ? busWData[BTN_W-1:0] : '0;
        btn_rise  = btn_deb & ~btn_prev;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= BUS_IDLE;
            cap      <= '0;
            btn_prev <= '0;
            btn_edge <= '0;
            irq_en   <= '0;
            irq      <= 1'b0;
            busAck   <= 1'b0;
            busErr   <= 1'b0;
            busRData <= '0;
        end else begin
            btn_prev <= btn_deb;
            // A new rising edge wins over a simultaneous W1C of the same bit.
            btn_edge <= (btn_edge & ~edge_clr) | btn_rise;
            if (wr_irq_en) begin
                irq_en <= busWData[BTN_W-1:0];
            end
            irq <= |(btn_edge & irq_en);

            busAck   <= 1'b0;
            busErr   <= 1'b0;
            busRData <= '0;
            case (state)
                BUS_IDLE: begin
                    if (accept) begin
                        cap.err   <= req_err;
                        cap.rdata <= (req_err || busWe) ? '0 : rd_mux;
                        state     <= BUS_PEND;
                    end
                end
                BUS_PEND: begin
                    busAck   <= 1'b1;
                    busErr   <= cap.err;
                    busRData <= cap.rdata;
                    state    <= BUS_ACK;
                end
                BUS_ACK:  state <= BUS_IDLE;
                default:  state <= BUS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_board_input_port.sv
// Scoreboard bench for board_input_port with a short debounce window.
module tb_board_input_port;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  sw = '0;
    logic [3:0]  btn = '0;
    logic        busReq = 1'b0;
    logic        busWe = 1'b0;
    logic [31:0] busAddr = '0;
    logic [31:0] busWData = '0;
    logic [31:0] busRData;
    logic        busAck;
    logic        busErr;
    logic        irq;

    always #5 clk = ~clk;

    board_input_port #(
        .BASE_ADDR      (32'h0000_2000),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw      (sw),
        .btn     (btn),
        .busReq  (busReq),
        .busWe   (busWe),
        .busAddr (busAddr),
        .busWData(busWData),
        .busRData(busRData),
        .busAck  (busAck),
        .busErr  (busErr),
        .irq     (irq)
    );

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    logic prev_ack = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Caller is positioned just after a rising edge; the request is accepted at the next one.
    task automatic xfer(input string name, input bit we, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] exp_rdata,
                        input bit exp_err, input bit hold = 1'b0);
        int lat;
        bit seen;
        exp_t e;
        e.name  = name;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        q.push_back(e);
        busReq   = 1'b1;
        busWe    = we;
        busAddr  = addr;
        busWData = data;
        seen = 1'b0;
        lat  = 0;
        for (int n = 1; n <= 8 && !seen; n++) begin
            @(posedge clk);
            #1;
            if (busAck) begin
                seen = 1'b1;
                lat  = n;
            end
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s_timeout: got no busAck, expected busAck within 8 cycles", name);
        end else begin
            check({name, "_latency"}, 32'(lat), 32'd2);
        end
        if (hold) tick(1);
        busReq   = 1'b0;
        busWe    = 1'b0;
        busAddr  = '0;
        busWData = '0;
        tick(1);
    endtask

    always @(negedge clk) begin
        if (busAck) begin
            tests++;
            if (prev_ack) begin
                fails++;
                $display("[TB] FAIL ack_pulse: got busAck high 2 cycles, expected 1");
            end
            if (q.size() == 0) begin
                fails++;
                $display("[TB] FAIL unexpected_ack: got busAck, expected none");
            end else begin
                exp_t e;
                e = q.pop_front();
                check({e.name, "_rdata"}, busRData, e.rdata);
                check({e.name, "_err"}, 32'(busErr), 32'(e.err));
            end
        end else begin
            tests++;
            if (busRData !== '0 || busErr !== 1'b0) begin
                fails++;
                $display("[TB] FAIL idle_outputs: got rdata=0x%08h err=%0b, expected 0/0",
                         busRData, busErr);
            end
        end
        prev_ack = busAck;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got no end of test, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        tick(3);
        check("rst_ack", 32'(busAck), 32'd0);
        check("rst_err", 32'(busErr), 32'd0);
        check("rst_rdata", busRData, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        rst_n = 1'b1;
        tick(1);
        xfer("rst_irq_en", 1'b0, 32'h200C, 32'd0, 32'h0, 1'b0);
        xfer("rst_edge", 1'b0, 32'h2008, 32'd0, 32'h0, 1'b0);

        // Switch read, with busReq held into the ack cycle
        sw = 10'h2A5;
        tick(10);
        xfer("sw_read", 1'b0, 32'h2000, 32'd0, 32'h2A5, 1'b0, 1'b1);
        tick(4);

        // Glitch shorter than the debounce window is ignored
        btn = 4'b0001;
        tick(3);
        btn = 4'b0000;
        tick(10);
        xfer("glitch_btn", 1'b0, 32'h2004, 32'd0, 32'h0, 1'b0);
        xfer("glitch_edge", 1'b0, 32'h2008, 32'd0, 32'h0, 1'b0);
        btn = 4'b0001;
        tick(8);
        xfer("held_btn", 1'b0, 32'h2004, 32'd0, 32'h1, 1'b0);
        xfer("held_edge", 1'b0, 32'h2008, 32'd0, 32'h1, 1'b0);

        // Interrupt enable and W1C clear
        xfer("w1c_pre", 1'b1, 32'h2008, 32'd1, 32'h0, 1'b0);
        btn = 4'b0000;
        tick(10);
        xfer("irq_en_wr", 1'b1, 32'h200C, 32'd1, 32'h0, 1'b0);
        tick(2);
        check("irq_idle", 32'(irq), 32'd0);
        btn = 4'b0001;
        tick(10);
        check("irq_set", 32'(irq), 32'd1);
        xfer("w1c_irq", 1'b1, 32'h2008, 32'd1, 32'h0, 1'b0);
        check("irq_clr", 32'(irq), 32'd0);
        xfer("edge_after_w1c", 1'b0, 32'h2008, 32'd0, 32'h0, 1'b0);
        xfer("irq_en_rd", 1'b0, 32'h200C, 32'd0, 32'h1, 1'b0);

        // W1C accepted on the exact edge where btn[2]'s edge bit sets
        btn = 4'b0101;
        tick(6);
        xfer("w1c_same", 1'b1, 32'h2008, 32'd4, 32'h0, 1'b0);
        xfer("edge_same", 1'b0, 32'h2008, 32'd0, 32'h4, 1'b0);

        // Error responses change no state
        xfer("err_base", 1'b0, 32'h3000, 32'd0, 32'h0, 1'b1);
        xfer("err_align", 1'b0, 32'h2002, 32'd0, 32'h0, 1'b1);
        xfer("err_wr_sw", 1'b1, 32'h2000, 32'h155, 32'h0, 1'b1);
        xfer("err_wr_btn", 1'b1, 32'h2004, 32'hF, 32'h0, 1'b1);
        xfer("err_wr_base", 1'b1, 32'h3008, 32'h4, 32'h0, 1'b1);
        xfer("sw_unchanged", 1'b0, 32'h2000, 32'd0, 32'h2A5, 1'b0);
        xfer("edge_unchanged", 1'b0, 32'h2008, 32'd0, 32'h4, 1'b0);

        // Reset one edge after acceptance aborts the transaction
        xfer("irq_en_all", 1'b1, 32'h200C, 32'hF, 32'h0, 1'b0);
        tick(1);
        check("irq_pre_rst", 32'(irq), 32'd1);
        busReq  = 1'b1;
        busWe   = 1'b0;
        busAddr = 32'h2000;
        tick(1);
        rst_n = 1'b0;
        tick(1);
        check("abort_ack", 32'(busAck), 32'd0);
        check("abort_err", 32'(busErr), 32'd0);
        check("abort_rdata", busRData, 32'd0);
        check("abort_irq", 32'(irq), 32'd0);
        busReq  = 1'b0;
        busAddr = '0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        xfer("irq_en_post_rst", 1'b0, 32'h200C, 32'd0, 32'h0, 1'b0);
        tick(12);
        xfer("edge_post_rst", 1'b0, 32'h2008, 32'd0, 32'h5, 1'b0);
        xfer("btn_post_rst", 1'b0, 32'h2004, 32'd0, 32'h5, 1'b0);
        tick(3);

        check("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
